// File: rtl/atm_pkg.sv
// Shared types and constants for the cashier sequencing controller.
// Included by the interface, the PIN capture block and the top.
package atm_pkg;

    localparam int DIG_W   = 4;
    localparam int PIN_W   = 16;
    localparam int MONTO_W = 32;
    localparam int BAL_W   = 64;
    localparam int INT_W   = 2;

    localparam logic [PIN_W-1:0] PIN_CORRECTO    = 16'h1234;
    localparam logic [BAL_W-1:0] BALANCE_INICIAL = 64'd1000;
    localparam int               MAX_INTENTOS    = 3;

    localparam logic [INT_W-1:0] INT_MAX  = INT_W'(MAX_INTENTOS);
    localparam logic [INT_W-1:0] INT_WARN = INT_W'(MAX_INTENTOS - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PIN_ENTRY    = 3'd1,
        PIN_CHECK    = 3'd2,
        ESPERA_MONTO = 3'd3,
        DEPOSITO     = 3'd4,
        RETIRO       = 3'd5,
        BLOQUEO      = 3'd6
    } state_t;

    function automatic logic [BAL_W-1:0] sat_add(
        input logic [BAL_W-1:0]   a,
        input logic [MONTO_W-1:0] b
    );
        logic [BAL_W:0] s;
        s = {1'b0, a} + {{(BAL_W - MONTO_W + 1){1'b0}}, b};
        return s[BAL_W] ? '1 : s[BAL_W-1:0];
    endfunction

endpackage

// File: rtl/atm_controller_if.sv
// Front-end bundle between the tester (master) and the controller (slave).
// Carries card, keypad, amount strobes and all result outputs.
interface atm_controller_if;
    import atm_pkg::*;

    logic               tarjeta_recibida;
    logic [DIG_W-1:0]   digito;
    logic               digito_stb;
    logic               tipo_trans;
    logic [MONTO_W-1:0] monto;
    logic               monto_stb;

    logic               pin_incorrecto;
    logic               advertencia;
    logic               bloqueo;
    logic               balance_actualizado;
    logic               entregar_dinero;
    logic               fondos_insuficientes;
    logic [BAL_W-1:0]   balance;
    logic               fin;

    modport master (
        output tarjeta_recibida, digito, digito_stb,
        output tipo_trans, monto, monto_stb,
        input  pin_incorrecto, advertencia, bloqueo,
        input  balance_actualizado, entregar_dinero,
        input  fondos_insuficientes, balance, fin
    );

    modport slave (
        input  tarjeta_recibida, digito, digito_stb,
        input  tipo_trans, monto, monto_stb,
        output pin_incorrecto, advertencia, bloqueo,
        output balance_actualizado, entregar_dinero,
        output fondos_insuficientes, balance, fin
    );

endinterface

// File: rtl/atm_controller_pin_capture.sv
// Keypad digit shifter and PIN comparator.
// Held clear by the controller whenever it is not collecting digits.
module pin_capture
    import atm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             stb,
    input  logic [DIG_W-1:0] digito,
    output logic             ultimo,
    output logic             pin_ok
);

    logic [PIN_W-1:0] pin_q;
    logic [1:0]       cnt;
    logic             pin_listo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_q     <= '0;
            cnt       <= '0;
            pin_listo <= 1'b0;
        end else if (clr) begin
            pin_q     <= '0;
            cnt       <= '0;
            pin_listo <= 1'b0;
        end else if (stb) begin
            pin_q <= {pin_q[PIN_W-DIG_W-1:0], digito};
            cnt   <= cnt + 2'd1;
            if (cnt == 2'd3)
                pin_listo <= 1'b1;
        end
    end

    // Fourth strobe of this attempt; lets the FSM leave without a bubble
    assign ultimo = stb && (cnt == 2'd3);
    assign pin_ok = pin_listo && (pin_q == PIN_CORRECTO);

endmodule

// File: rtl/atm_controller.sv
// Cashier sequencing FSM: card, PIN with lockout, one deposit or withdrawal.
// Owns the attempt counter, balance register and all registered outputs.
module atm_controller
    import atm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    atm_controller_if.slave  bus
);

    state_t             state;
    logic [INT_W-1:0]   intentos;
    logic [INT_W-1:0]   intentos_nx;
    logic [MONTO_W-1:0] monto_q;
    logic [BAL_W-1:0]   balance_q;

    logic pin_inc_q;
    logic adv_q;
    logic blq_q;
    logic bact_q;
    logic ent_q;
    logic fond_q;
    logic fin_q;

    logic clr;
    logic stb;
    logic ultimo;
    logic pin_ok;

    assign clr = (state != PIN_ENTRY);
    assign stb = (state == PIN_ENTRY) && bus.digito_stb;
    assign intentos_nx = intentos + 1'b1;

    pin_capture u_pin (
        .clk    (clk),
        .rst_n  (reset),
        .clr    (clr),
        .stb    (stb),
        .digito (bus.digito),
        .ultimo (ultimo),
        .pin_ok (pin_ok)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            intentos  <= '0;
            monto_q   <= '0;
            balance_q <= BALANCE_INICIAL;
            pin_inc_q <= 1'b0;
            adv_q     <= 1'b0;
            blq_q     <= 1'b0;
            bact_q    <= 1'b0;
            ent_q     <= 1'b0;
            fond_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            pin_inc_q <= 1'b0;
            bact_q    <= 1'b0;
            ent_q     <= 1'b0;
            fond_q    <= 1'b0;
            fin_q     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.tarjeta_recibida)
                        state <= PIN_ENTRY;
                end
                PIN_ENTRY: begin
                    if (ultimo)
                        state <= PIN_CHECK;
                end
                PIN_CHECK: begin
                    if (pin_ok) begin
                        intentos <= '0;
                        adv_q    <= 1'b0;
                        state    <= ESPERA_MONTO;
                    end else begin
                        pin_inc_q <= 1'b1;
                        intentos  <= intentos_nx;
                        if (intentos_nx == INT_MAX) begin
                            blq_q <= 1'b1;
                            state <= BLOQUEO;
                        end else begin
                            if (intentos_nx == INT_WARN)
                                adv_q <= 1'b1;
                            state <= PIN_ENTRY;
                        end
                    end
                end
                ESPERA_MONTO: begin
                    if (bus.monto_stb) begin
                        monto_q <= bus.monto;
                        state   <= bus.tipo_trans ? RETIRO : DEPOSITO;
                    end
                end
                DEPOSITO: begin
                    balance_q <= sat_add(balance_q, monto_q);
                    bact_q    <= 1'b1;
                    fin_q     <= 1'b1;
                    state     <= IDLE;
                end
                RETIRO: begin
                    if ({32'd0, monto_q} > balance_q) begin
                        fond_q <= 1'b1;
                    end else begin
                        balance_q <= balance_q - {32'd0, monto_q};
                        bact_q    <= 1'b1;
                        ent_q     <= 1'b1;
                    end
                    fin_q <= 1'b1;
                    state <= IDLE;
                end
                BLOQUEO: begin
                    state <= BLOQUEO;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pin_incorrecto       = pin_inc_q;
    assign bus.advertencia          = adv_q;
    assign bus.bloqueo              = blq_q;
    assign bus.balance_actualizado  = bact_q;
    assign bus.entregar_dinero      = ent_q;
    assign bus.fondos_insuficientes = fond_q;
    assign bus.balance              = balance_q;
    assign bus.fin                  = fin_q;

endmodule

// File: tb/tb_atm_controller.sv
// Randomized scoreboard bench for atm_controller against a session-level
// model of balance, attempts and lockout.
module tb_atm_controller;

    typedef struct {
        logic [6:0]  flags;
        logic [63:0] bal;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    atm_controller_if bus();

    atm_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int checks = 0;
    int passed = 0;

    longint unsigned m_bal;
    int m_att;

    // {pin_inc, adv, blq, bact, ent, fond, fin}
    function automatic logic [6:0] outv();
        return {bus.pin_incorrecto, bus.advertencia, bus.bloqueo,
                bus.balance_actualizado, bus.entregar_dinero,
                bus.fondos_insuficientes, bus.fin};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        logic [6:0] v;
        v = outv();
        if (reset === 1'b1 &&
            (v[6] | v[3] | v[2] | v[1] | v[0])) begin
            if (q.size() == 0) begin
                chk("unexpected_event", 64'(v), 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_flags", 64'(v), 64'(e.flags));
                chk("event_balance", bus.balance, e.bal);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.tarjeta_recibida = 1'b0;
        bus.digito_stb = 1'b0;
        bus.monto_stb = 1'b0;
        bus.digito = '0;
        bus.tipo_trans = 1'b0;
        bus.monto = '0;
    endtask

    task automatic do_reset();
        #1 reset = 1'b0;
        quiet();
        tick();
        tick();
        reset = 1'b1;
        m_bal = 64'd1000;
        m_att = 0;
        q.delete();
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    task automatic card();
        bus.tarjeta_recibida = 1'b1;
        tick();
        bus.tarjeta_recibida = 1'b0;
    endtask

    task automatic digits(input logic [15:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.monto_stb = 1'($urandom_range(0, 1));
                bus.digito = 4'($urandom);
                tick();
            end
            bus.monto_stb = 1'b0;
            bus.digito = p[15-4*i -: 4];
            bus.digito_stb = 1'b1;
            tick();
            bus.digito_stb = 1'b0;
        end
    endtask

    task automatic pin(input logic [15:0] p);
        exp_t e;
        if (p == 16'h1234) begin
            m_att = 0;
        end else begin
            m_att++;
            e.flags = {1'b1, 1'(m_att >= 2), 1'(m_att >= 3), 4'b0};
            e.bal = m_bal;
            q.push_back(e);
        end
        digits(p, 4);
        tick();
    endtask

    task automatic trans(input logic tipo, input logic [31:0] amt);
        exp_t e;
        repeat ($urandom_range(0, 2)) begin
            bus.digito_stb = 1'($urandom_range(0, 1));
            tick();
        end
        bus.digito_stb = 1'($urandom_range(0, 1));
        if (!tipo) begin
            if (m_bal + amt < m_bal) m_bal = '1;
            else m_bal = m_bal + amt;
            e.flags = 7'b0001001;
        end else if (64'(amt) > m_bal) begin
            e.flags = 7'b0000011;
        end else begin
            m_bal = m_bal - amt;
            e.flags = 7'b0001101;
        end
        e.bal = m_bal;
        q.push_back(e);
        bus.tipo_trans = tipo;
        bus.monto = amt;
        bus.monto_stb = 1'b1;
        tick();
        quiet();
        tick();
        tick();
        tick();
    endtask

    function automatic logic [15:0] wrong_pin();
        logic [15:0] p;
        p = 16'($urandom);
        if (p == 16'h1234) p = 16'h9999;
        return p;
    endfunction

    function automatic logic [31:0] pick_amt();
        case ($urandom_range(0, 5))
            0: return 32'(m_bal);
            1: return 32'(m_bal) + 32'd1;
            2: return 32'd0;
            default: return 32'($urandom_range(0, 2000));
        endcase
    endfunction

    initial begin
        quiet();
        m_bal = 64'd1000;
        m_att = 0;
        tick();
        chk("reset_outputs", 64'(outv()), 64'd0);
        chk("reset_balance", bus.balance, 64'd1000);
        reset = 1'b1;
        repeat (20) tick();
        chk("idle_outputs", 64'(outv()), 64'd0);
        chk("idle_balance", bus.balance, 64'd1000);

        card(); pin(16'h1234); trans(1'b0, 32'd500);
        drain();
        chk("deposit_500", bus.balance, 64'd1500);

        do_reset();
        card(); pin(16'h1234); trans(1'b1, 32'd300);
        drain();
        chk("withdraw_300", bus.balance, 64'd700);

        do_reset();
        card(); pin(16'h1234); trans(1'b1, 32'd5000);
        drain();
        chk("withdraw_5000", bus.balance, 64'd1000);

        card(); pin(16'h9999); pin(16'h1234);
        chk("adv_after_clear", 64'(bus.advertencia), 64'd0);
        trans(1'b0, 32'd1);
        card(); pin(16'h9999); pin(16'h9999);
        chk("adv_second_fail", 64'(bus.advertencia), 64'd1);
        chk("not_blocked", 64'(bus.bloqueo), 64'd0);
        pin(16'h1234); trans(1'b1, 32'd1);
        drain();

        for (int s = 0; s < 40; s++) begin
            card();
            while ($urandom_range(0, 9) < 4 && m_att < 2)
                pin(wrong_pin());
            pin(16'h1234);
            trans(1'($urandom_range(0, 1)), pick_amt());
            drain();
        end

        do_reset();
        card();
        digits(16'h1234, 2);
        do_reset();
        card(); pin(16'h1234); trans(1'b0, 32'd25);
        drain();
        chk("after_midreset", bus.balance, 64'd1025);

        do_reset();
        card();
        pin(16'h9999); pin(16'h9999); pin(16'h9999);
        drain();
        chk("blocked", 64'(bus.bloqueo), 64'd1);
        card();
        digits(16'h1234, 4);
        bus.monto = 32'd100;
        bus.monto_stb = 1'b1;
        tick();
        quiet();
        repeat (5) tick();
        chk("block_sticky", 64'(outv()), 64'b0110000);
        chk("block_balance", bus.balance, 64'd1000);

        do_reset();
        chk("reset_clears", 64'(outv()), 64'd0);
        chk("reset_bal", bus.balance, 64'd1000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
